reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Controller that sequences reset release across the BNN datapath stages: input buffer, binary conv/popcount layer, and classifier/output.
- Input is the already-synchronized chip reset from the reset synchronizer.
- After a programmable hold time, releases each stage's local reset in order, with a programmable gap between releases.
- Also services single-cycle soft-reset requests from the host-side control logic, and reports when the whole datapath is out of reset.

Parameters:
NUM_STAGES, 3, number of datapath stages with their own active-low reset (>=1)
HOLD_CYCLES, 4, cycles all stage resets stay asserted after the reset source goes inactive (>=1)
GAP_CYCLES, 2, cycles between consecutive stage releases (>=1)
CNT_W, 8, counter width; must hold max(HOLD_CYCLES, GAP_CYCLES)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sync_rst_n  input  1  synchronized reset from the synchronizer, active-low; low means hold datapath in reset
soft_rst_req  input  1  one-cycle soft-reset request pulse
soft_rst_ack  output  1  one-cycle acknowledge of an accepted soft reset
stage_rst_n  output  NUM_STAGES  per-stage active-low reset; bit 0 is released first
busy  output  1  high while any stage is held or sequencing
ready  output  1  high when all stages are released

Behaviour:
- Clocking and reset: single clock domain, registered outputs. reset_n is asynchronous and active-low.
  - While reset_n=0: state=HOLD, cnt=0, idx=0, stage_rst_n=all 0, soft_rst_ack=0, busy=1, ready=0.
- States: HOLD, RELEASE, RUN.
- HOLD:
  - cnt increments on each edge where sync_rst_n=1 and no soft request is present.
  - Any edge with sync_rst_n=0 forces cnt=0.
  - On the edge where cnt==HOLD_CYCLES-1 (and sync_rst_n=1): stage_rst_n[0]<=1, idx<=1, cnt<=0, go RELEASE.
  - If NUM_STAGES==1, go directly to RUN on that edge instead.
- RELEASE:
  - cnt increments each edge.
  - On the edge where cnt==GAP_CYCLES-1: stage_rst_n[idx]<=1, cnt<=0, idx<=idx+1.
  - If idx==NUM_STAGES-1 on that edge, go RUN and, on the same edge, ready<=1 and busy<=0.
  - Already-released bits stay 1.
- RUN: holds all stage_rst_n=1, ready=1, busy=0.
- Release timing: edge 1 is the first edge with sync_rst_n sampled 1.
  - stage k goes high after edge HOLD_CYCLES + k*GAP_CYCLES.
  - ready goes high on the same edge as the last stage.
- Priority each edge: sync_rst_n=0 > soft_rst_req > normal progression.
- sync_rst_n=0 in any state, on the next edge:
  - stage_rst_n<=0, ready<=0, busy<=1, cnt<=0, idx<=0, go HOLD.
  - soft_rst_req is ignored and soft_rst_ack stays 0.
- soft_rst_req=1 with sync_rst_n=1, in any state, on the next edge:
  - soft_rst_ack<=1 for exactly one cycle.
  - stage_rst_n<=0, ready<=0, busy<=1, cnt<=0, idx<=0, go HOLD.
  - A request arriving in HOLD restarts the hold count.
  - Back-to-back requests are each acked.
- soft_rst_ack is 0 in every cycle not immediately following an accepted request.
- Invariant: stage_rst_n is always thermometer-coded, i.e. bit k=1 implies bits <k are 1. No stage is ever released before its predecessor.
- Invariant: ready == &stage_rst_n, and busy == ~ready, at all times.

Test Plan:
- Power-up, defaults (3/4/2):
  - Stimulus: reset_n low 3 cycles, then high with sync_rst_n=1.
  - Required: stage_rst_n=000 through edge 3; 001 after edge 4; 011 after edge 6; 111 and ready=1, busy=0 after edge 8.
- Slow synchronizer:
  - Stimulus: sync_rst_n held 0 for 5 edges after reset_n rises, then 1.
  - Required: hold count starts only when sync_rst_n=1; stage0 is released 4 edges later.
- Soft reset in RUN:
  - Stimulus: one-cycle soft_rst_req once ready=1.
  - Required: next edge gives stage_rst_n=000, soft_rst_ack=1 for one cycle, ready=0; full release sequence then repeats with identical timing (001/011/111 at +4/+6/+8).
- Soft reset mid-RELEASE:
  - Stimulus: soft_rst_req while stage_rst_n=001.
  - Required: all bits return to 0, ack pulses, sequence restarts from HOLD with cnt=0.
- sync_rst_n drop vs. request:
  - Stimulus: sync_rst_n falls in RUN; separately, sync_rst_n=0 and soft_rst_req=1 on the same cycle.
  - Required: all stages reset next edge, no ack; sequence resumes only after sync_rst_n returns to 1.
- Async reset mid-sequence:
  - Stimulus: reset_n pulsed low between clock edges during RELEASE.
  - Required: outputs return to reset values immediately, without waiting for a clock edge.
- All scenarios: checker confirms thermometer-coded stage_rst_n and ready == &stage_rst_n every cycle.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Reset-sequencer control bundle: synchronized reset and soft-reset handshake in,
// staged datapath resets and status out.
// Ports: sync_rst_n, soft_rst_req (host -> sequencer); soft_rst_ack, stage_rst_n, busy, ready (sequencer -> host/datapath).
// master = host/control side that drives the request inputs; slave = the sequencer itself.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  sync_rst_n;
    logic                  soft_rst_req;
    logic                  soft_rst_ack;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  busy;
    logic                  ready;

    modport master (
        output sync_rst_n,
        output soft_rst_req,
        input  soft_rst_ack,
        input  stage_rst_n,
        input  busy,
        input  ready
    );

    modport slave (
        input  sync_rst_n,
        input  soft_rst_req,
        output soft_rst_ack,
        output stage_rst_n,
        output busy,
        output ready
    );
endinterface

// File: rtl/reset_sequencer.sv
// Sequences per-stage active-low reset release for the BNN datapath after a hold period.
// Latency: stage k released HOLD_CYCLES + k*GAP_CYCLES edges after sync_rst_n is first sampled high; ack one edge after request.
// No backpressure: soft_rst_req is always accepted (unless sync_rst_n is low) and acknowledged with a single-cycle pulse.
//
// Ports: clk, reset_n (async active-low); bus.slave carries sync_rst_n, soft_rst_req,
//        soft_rst_ack, stage_rst_n[NUM_STAGES-1:0] (bit 0 released first), busy, ready.
// Parameter constraints: NUM_STAGES>=1, HOLD_CYCLES>=1, GAP_CYCLES>=1,
//        CNT_W wide enough to hold max(HOLD_CYCLES, GAP_CYCLES).
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    reset_sequencer_if.slave       bus
);

    // idx needs at least one bit even for a single-stage datapath.
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [NUM_STAGES-1:0] stage_q;
    logic                  ack_q;
    logic                  busy_q;
    logic                  ready_q;

    // Single registered FSM. Priority each edge:
    //   sync_rst_n low  > soft_rst_req > normal progression.
    // Both reset causes collapse into the same HOLD entry; only the soft request acks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_HOLD;
            cnt     <= '0;
            idx     <= '0;
            stage_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            // Ack is a pulse; it is only re-raised by an accepted request below.
            ack_q <= 1'b0;

            if (!bus.sync_rst_n) begin
                // Chip-level reset still asserted: request (if any) is dropped, no ack.
                state   <= S_HOLD;
                cnt     <= '0;
                idx     <= '0;
                stage_q <= '0;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
            end else if (bus.soft_rst_req) begin
                // Accepted soft reset: restart from a fresh hold count in every state,
                // including HOLD itself. Back-to-back requests each get their own ack.
                ack_q   <= 1'b1;
                state   <= S_HOLD;
                cnt     <= '0;
                idx     <= '0;
                stage_q <= '0;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
            end else begin
                unique case (state)
                    S_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            // Hold period done: first stage comes out of reset now.
                            stage_q[0] <= 1'b1;
                            cnt        <= '0;
                            if (NUM_STAGES == 1) begin
                                state   <= S_RUN;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end else begin
                                idx   <= IDX_W'(1);
                                state <= S_RELEASE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    S_RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            // Only bit idx is set; lower bits are already 1, which keeps
                            // the vector thermometer-coded.
                            stage_q[idx] <= 1'b1;
                            cnt          <= '0;
                            idx          <= idx + IDX_W'(1);
                            if (idx == IDX_LAST) begin
                                // Last stage released: ready on the same edge.
                                state   <= S_RUN;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    S_RUN: begin
                        stage_q <= '1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end

                    default: begin
                        // Unreachable encoding: fall back to a clean hold.
                        state   <= S_HOLD;
                        cnt     <= '0;
                        idx     <= '0;
                        stage_q <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.stage_rst_n  = stage_q;
    assign bus.soft_rst_ack = ack_q;
    assign bus.busy         = busy_q;
    assign bus.ready        = ready_q;

`ifndef SYNTHESIS
    // Thermometer code from bit 0 means the vector is of the form 2^m-1.
    a_thermo: assert property (@(posedge clk) disable iff (!reset_n)
        ((stage_q & (stage_q + NUM_STAGES'(1))) == '0));
    a_ready: assert property (@(posedge clk) disable iff (!reset_n)
        (ready_q == (&stage_q)));
    a_busy: assert property (@(posedge clk) disable iff (!reset_n)
        (busy_q == !ready_q));
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized and directed bench for reset_sequencer with a queue-based scoreboard.
// Expected outputs come from an elapsed-edge model: stage k is out of reset once
// HOLD + k*GAP uninterrupted edges have passed since the last reset cause.
module tb_reset_sequencer;

    localparam int NS   = 3;
    localparam int HOLD = 4;
    localparam int GAP  = 2;

    typedef struct {
        logic [NS-1:0] stage;
        logic          ack;
        logic          ready;
        logic          busy;
        int            id;
    } exp_t;

    logic clk;
    logic reset_n;

    reset_sequencer_if #(.NUM_STAGES(NS)) bus();

    reset_sequencer #(
        .NUM_STAGES (NS),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .CNT_W      (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t async_q[$];
    event async_ev;

    int n_checks = 0;
    int n_pass   = 0;
    int n_issue  = 0;

    // Reference model: edges elapsed since the last reset cause.
    int t_run = 0;

    function automatic exp_t expect_from(input int t, input logic ack, input int id);
        exp_t e;
        e.stage = '0;
        for (int k = 0; k < NS; k++)
            if (t >= HOLD + k * GAP) e.stage[k] = 1'b1;
        e.ready = (e.stage == {NS{1'b1}});
        e.busy  = !e.ready;
        e.ack   = ack;
        e.id    = id;
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        n_checks++;
        if (bus.stage_rst_n === e.stage && bus.soft_rst_ack === e.ack &&
            bus.ready === e.ready && bus.busy === e.busy) begin
            n_pass++;
        end else begin
            $display("FAIL %s #%0d: got stage=%b ack=%b ready=%b busy=%b, expected stage=%b ack=%b ready=%b busy=%b",
                     name, e.id, bus.stage_rst_n, bus.soft_rst_ack, bus.ready, bus.busy,
                     e.stage, e.ack, e.ready, e.busy);
        end
    endtask

    task automatic check_inv(input int id);
        logic [NS-1:0] s;
        s = bus.stage_rst_n;
        n_checks++;
        if (((s & (s + NS'(1))) == '0) && (bus.ready === (&s)) && (bus.busy === !bus.ready)) begin
            n_pass++;
        end else begin
            $display("FAIL invariant #%0d: got stage=%b ready=%b busy=%b, required thermometer stage with ready=&stage and busy=~ready",
                     id, s, bus.ready, bus.busy);
        end
    endtask

    // Drive inputs for the coming edge and push what that edge must produce.
    task automatic drive(input logic rst_low, input logic sync, input logic req);
        logic ack;
        bus.sync_rst_n   = sync;
        bus.soft_rst_req = req;
        ack = 1'b0;
        if (rst_low || !sync) begin
            t_run = 0;
        end else if (req) begin
            t_run = 0;
            ack   = 1'b1;
        end else if (t_run < 1000) begin
            t_run++;
        end
        n_issue++;
        exp_q.push_back(expect_from(t_run, ack, n_issue));
    endtask

    task automatic step(input logic sync, input logic req);
        @(negedge clk);
        drive(1'b0, sync, req);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    // Monitor: every edge with an outstanding expectation is checked.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_out("edge", e);
                check_inv(e.id);
            end
        end
    end

    // Checks made between clock edges (asynchronous reset).
    initial begin : async_monitor
        exp_t e;
        forever begin
            @(async_ev);
            if (async_q.size() > 0) begin
                e = async_q.pop_front();
                check_out("async_reset", e);
            end
        end
    end

    initial begin : stimulus
        exp_t ea;
        reset_n          = 1'b0;
        bus.sync_rst_n   = 1'b1;
        bus.soft_rst_req = 1'b0;

        // Power-up: reset_n low for 3 edges, then release with sync high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        run(11);

        // Soft reset in RUN, then the full sequence repeats.
        step(1'b1, 1'b1);
        run(10);

        // Soft reset while only stage 0 is out of reset.
        step(1'b1, 1'b1);
        run(5);
        step(1'b1, 1'b1);
        run(10);

        // Back-to-back requests, and a request during HOLD.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        run(2);
        step(1'b1, 1'b1);
        run(10);

        // sync_rst_n drop in RUN; then sync low together with a request.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        run(10);
        step(1'b0, 1'b1);
        run(10);

        // Slow synchronizer after a fresh power-on reset.
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        run(10);

        // Async reset pulse between edges during RELEASE.
        step(1'b1, 1'b1);
        run(5);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        t_run = 0;
        #1;
        ea = expect_from(0, 1'b0, -1);
        async_q.push_back(ea);
        ->async_ev;
        #1;
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        run(10);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic s;
            logic r;
            s = ($urandom_range(0, 19) != 0);
            r = ($urandom_range(0, 11) == 0);
            step(s, r);
        end
        bus.soft_rst_req = 1'b0;

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0 && async_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size() + async_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
